// File: rtl/bist_pkg.sv
// Shared types and constants for the March-style BIST address sequencer.
package bist_pkg;

  localparam int unsigned PASS_LEN = 16384;
  localparam int unsigned ADDR_W   = $clog2(PASS_LEN);

  // Feedback taps at bits 13, 4, 2 and 0.
  localparam logic [ADDR_W-1:0] LFSR_TAPS = 14'h2015;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} bist_state_e;

  function automatic logic [ADDR_W-1:0] lfsr_next(input logic [ADDR_W-1:0] q);
    return {q[ADDR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  // Inverse step: q[0] was the feedback bit, so recover the bit that shifted out.
  function automatic logic [ADDR_W-1:0] lfsr_prev(input logic [ADDR_W-1:0] q);
    return {q[0] ^ q[5] ^ q[3] ^ q[1], q[ADDR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr14.sv
// 14-bit Fibonacci LFSR with synchronous load and step.
module lfsr14
  import bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] seed,
  input  logic              step,
  output logic [ADDR_W-1:0] q
);

  logic [ADDR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 14'h0001;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bist_addr_seq.sv
// March-style BIST: write pass then read/compare pass over all 16384 addresses in LFSR order,
// address 0 issued as an extra final beat. All outputs come straight from flops.
module bist_addr_seq
  import bist_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       RD_LAT  = 1,
  parameter logic [ADDR_W-1:0] SEED    = 14'h0001,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              select,
  output logic [ADDR_W-1:0] inter_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr
);

  // The LFSR runs one beat ahead of addr_q, so it is loaded with the successor of SEED.
  localparam logic [ADDR_W-1:0] SEED_NEXT = lfsr_next(SEED);
  localparam logic [ADDR_W-1:0] LAST_ADDR = lfsr_prev(SEED);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              zero_q, zero_d;
  logic [2:0]        drain_q, drain_d;
  logic              sel_q, sel_d, busy_q, busy_d, we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d, pass_q, pass_d, mis_q, mis_d;
  logic [ADDR_W-1:0] fail_q, fail_d;

  logic [RD_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic [RD_LAT-1:0][DATA_W-1:0] pipe_exp_q, pipe_exp_d;

  logic              lfsr_load, lfsr_step;
  logic [ADDR_W-1:0] lfsr_q;
  logic              cmp_bad;

  lfsr14 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (SEED_NEXT),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign cmp_bad = pipe_vld_q[RD_LAT-1] && (mem_rdata != pipe_exp_q[RD_LAT-1]);

  always_comb begin
    pipe_vld_d  = pipe_vld_q;
    pipe_addr_d = pipe_addr_q;
    pipe_exp_d  = pipe_exp_q;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
    end
    pipe_vld_d[0]  = (state_q == StRead);
    pipe_addr_d[0] = addr_q;
    pipe_exp_d[0]  = wdata_q;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    zero_d    = zero_q;
    drain_d   = drain_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    done_d    = done_q;
    pass_d    = pass_q;
    mis_d     = mis_q | cmp_bad;
    fail_d    = fail_q;
    if (cmp_bad && !mis_q) begin
      fail_d = pipe_addr_q[RD_LAT-1];
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StWrite;
          addr_d    = SEED;
          zero_d    = 1'b0;
          lfsr_load = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          mis_d     = 1'b0;
          fail_d    = '0;
        end
      end
      StWrite, StRead: begin
        if (zero_q) begin
          zero_d = 1'b0;
          if (state_q == StWrite) begin
            state_d   = StRead;
            addr_d    = SEED;
            lfsr_load = 1'b1;
          end else begin
            state_d = StDrain;
            addr_d  = '0;
            drain_d = '0;
          end
        end else if (addr_q == LAST_ADDR) begin
          addr_d = '0;
          zero_d = 1'b1;
        end else begin
          addr_d    = lfsr_q;
          lfsr_step = 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 3'(RD_LAT - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = ~mis_d;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d  = (state_d == StWrite) || (state_d == StRead) || (state_d == StDrain);
    sel_d   = busy_d;
    we_d    = (state_d == StWrite);
    wdata_d = addr_d[DATA_W-1:0] ^ PATTERN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      zero_q      <= 1'b0;
      drain_q     <= '0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mis_q       <= 1'b0;
      fail_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
      pipe_exp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      zero_q      <= zero_d;
      drain_q     <= drain_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      mis_q       <= mis_d;
      fail_q      <= fail_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_exp_q  <= pipe_exp_d;
    end
  end

  assign select     = sel_q;
  assign inter_addr = addr_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_q;

endmodule

// File: tb/tb_bist_addr_seq.sv
// Directed bench for bist_addr_seq: address order, clean run, injected faults, mid-test reset.
module tb_bist_addr_seq;

  localparam logic [13:0] FaultA = 14'h1234;
  localparam logic [13:0] FaultB = 14'h0002;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        select, mem_we, busy, done, pass;
  logic [13:0] inter_addr, fail_addr;
  logic [7:0]  mem_wdata, mem_rdata, rd_val;

  logic [7:0]  mem [16384];
  logic        fault_a_en = 1'b0;
  logic        fault_b_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 if (clk_en) clk = ~clk;

  // Pattern chosen so both fault addresses store 0 in bit 0, making stuck-at-1 visible.
  bist_addr_seq #(
    .DATA_W  (8),
    .RD_LAT  (1),
    .SEED    (14'h0001),
    .PATTERN (8'h5A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .select     (select),
    .inter_addr (inter_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_addr  (fail_addr)
  );

  always_comb begin
    rd_val = mem[inter_addr];
    if (fault_a_en && inter_addr == FaultA) rd_val[0] = 1'b1;
    if (fault_b_en && inter_addr == FaultB) rd_val[0] = 1'b1;
  end

  always @(posedge clk) begin
    if (mem_we) mem[inter_addr] <= mem_wdata;
    mem_rdata <= rd_val;
  end

  function automatic logic [13:0] lfsr_m(input logic [13:0] x);
    return {x[12:0], x[13] ^ x[4] ^ x[2] ^ x[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge inside cycle 1 (start sampled at edge 0).
  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [13:0] first4 [4];
  bit          seen [16384];
  logic [13:0] exp_a, exp_first;
  int          bad_ord, bad_we, dups, cyc, idx_a, idx_b;

  initial begin
    first4 = '{14'h0001, 14'h0003, 14'h0007, 14'h000E};
    bad_ord = 0;
    bad_we  = 0;
    dups    = 0;

    // Reset applied with the clock stopped.
    #1 rst_n = 1'b0;
    #4;
    check("rst_select", select, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_inter_addr", inter_addr, 0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_select", select, 0);

    // Run 1: address order over the write pass, then reset in the middle of READ.
    start_run();
    exp_a = 14'h0001;
    for (int k = 1; k <= 17000; k++) begin
      if (k <= 16384) begin
        if (!mem_we || !select || !busy) bad_we++;
        if (seen[inter_addr]) dups++;
        seen[inter_addr] = 1'b1;
        if (inter_addr != ((k == 16384) ? 14'h0000 : exp_a)) bad_ord++;
        exp_a = lfsr_m(exp_a);
      end
      if (k <= 4) check($sformatf("addr_beat%0d", k), inter_addr, first4[k-1]);
      if (k == 16384) check("zero_beat", inter_addr, 0);
      if (k == 16385) begin
        check("read_first_addr", inter_addr, 14'h0001);
        check("read_we", mem_we, 0);
        check("read_select", select, 1);
      end
      if (k < 17000) @(negedge clk);
    end
    check("write_order_errs", bad_ord, 0);
    check("write_ctrl_errs", bad_we, 0);
    check("write_dup_addrs", dups, 0);

    #2 rst_n = 1'b0;
    #1;
    check("midrst_select", select, 0);
    check("midrst_busy", busy, 0);
    check("midrst_we", mem_we, 0);
    check("midrst_addr", inter_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Expected first failing address: whichever fault comes first in LFSR read order.
    exp_a = 14'h0001;
    idx_a = -1;
    idx_b = -1;
    for (int i = 0; i < 16383; i++) begin
      if (exp_a == FaultA) idx_a = i;
      if (exp_a == FaultB) idx_b = i;
      exp_a = lfsr_m(exp_a);
    end
    exp_first = (idx_a < idx_b) ? FaultA : FaultB;

    // Run 2: two stuck-at-1 faults.
    fault_a_en = 1'b1;
    fault_b_en = 1'b1;
    start_run();
    check("rerun_first_addr", inter_addr, 14'h0001);
    run_until_done(1, cyc);
    check("fault_done_cycle", cyc, 32770);
    check("fault_pass", pass, 0);
    check("fault_fail_addr", fail_addr, exp_first);
    check("fault_select", select, 0);

    // Run 3: clean memory, started from DONE, with a stray start during WRITE.
    fault_a_en = 1'b0;
    fault_b_en = 1'b0;
    start_run();
    check("done_clear", done, 0);
    check("rerun_busy", busy, 1);
    cyc = 1;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    check("stray_start_addr_live", select, 1);
    run_until_done(cyc, cyc);
    check("clean_done_cycle", cyc, 32770);
    check("clean_pass", pass, 1);
    check("clean_fail_addr", fail_addr, 0);
    check("clean_select", select, 0);
    check("clean_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("done_held", done, 1);
    check("pass_held", pass, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
